// File: rtl/frame_reader.sv
// frame_reader: reads the ping-pong frame RAM, inserts service words in slots addr[1:0]==0, and shifts words out MSB-first.
// Latency: first bit is 3+RD_LAT clocks after enable is seen; then back-to-back words of BIT_DIV clocks per bit.
// No backpressure: free-running once started, enable honoured at word boundaries. SERIAL_PARITY_EN appends an odd-parity bit.
module frame_reader #(
    parameter int BIT_DIV = 4,
    parameter int RD_LAT  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [11:0] rdDAT,
    output logic [9:0]  rdADR,
    output logic        bufSwitch,
    output logic        serDAT,
    output logic        serSTB,
    output logic        wordSTB,
    output logic        frameSTB
);

`ifdef SERIAL_PARITY_EN
    localparam int NB = 13;
`else
    localparam int NB = 12;
`endif
    localparam int WORD_CLKS = NB * BIT_DIV;
    localparam int DW        = $clog2(BIT_DIV);
    localparam int PW        = $clog2(WORD_CLKS);

    localparam logic [DW-1:0] DIV_LAST  = DW'(BIT_DIV - 1);
    localparam logic [PW-1:0] POS_LAST  = PW'(WORD_CLKS - 1);
    localparam logic [PW-1:0] POS_CAP   = PW'(RD_LAT);
    localparam logic [2:0]    PR_CAP    = 3'(RD_LAT);
    localparam logic [2:0]    PR_LOAD   = 3'(RD_LAT + 1);
    localparam logic [9:0]    LAST_ADDR = 10'd1023;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        SHIFT
    } state_t;

    state_t          state;
    logic [DW-1:0]   div_cnt;
    logic [PW-1:0]   word_pos;
    logic [2:0]      prime_cnt;
    logic [3:0]      frame_cnt;
    logic [11:0]     next_word;
    logic [NB-1:0]   shifter;
    logic [11:0]     fetch_word;

    // Service slots never come from RAM; they carry the slot index and frame count.
    always_comb begin
        fetch_word = rdDAT;
        if (rdADR[1:0] == 2'b00) begin
            fetch_word = {rdADR[9:2], frame_cnt};
        end
    end

    function automatic logic [NB-1:0] frame_bits(input logic [11:0] w);
`ifdef SERIAL_PARITY_EN
        return {w, ~^w};
`else
        return w;
`endif
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            div_cnt   <= '0;
            word_pos  <= '0;
            prime_cnt <= '0;
            frame_cnt <= '0;
            next_word <= '0;
            shifter   <= '0;
            rdADR     <= '0;
            bufSwitch <= 1'b0;
            serDAT    <= 1'b0;
            serSTB    <= 1'b0;
            wordSTB   <= 1'b0;
            frameSTB  <= 1'b0;
        end else begin
            serSTB   <= 1'b0;
            wordSTB  <= 1'b0;
            frameSTB <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state     <= PRIME;
                        rdADR     <= '0;
                        prime_cnt <= '0;
                    end
                end
                PRIME: begin
                    prime_cnt <= prime_cnt + 3'd1;
                    if (prime_cnt == PR_CAP) begin
                        next_word <= fetch_word;
                    end
                    if (prime_cnt == PR_LOAD) begin
                        shifter  <= frame_bits(next_word);
                        div_cnt  <= '0;
                        word_pos <= '0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (div_cnt == '0) begin
                        serSTB  <= 1'b1;
                        serDAT  <= shifter[NB-1];
                        shifter <= shifter << 1;
                    end
                    // rdADR names the word being sent when its first bit goes out.
                    if (word_pos == '0) begin
                        wordSTB  <= 1'b1;
                        frameSTB <= (rdADR == '0);
                        rdADR    <= rdADR + 10'd1;
                        if (rdADR == LAST_ADDR) begin
                            bufSwitch <= ~bufSwitch;
                            frame_cnt <= frame_cnt + 4'd1;
                        end
                    end
                    if (word_pos == POS_CAP) begin
                        next_word <= fetch_word;
                    end
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                    if (word_pos == POS_LAST) begin
                        word_pos <= '0;
                        if (enable) begin
                            shifter <= frame_bits(next_word);
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        word_pos <= word_pos + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_reader.sv
// Bench for frame_reader: random two-bank RAM, serial decoder and a word-level frame model.
`timescale 1ns/1ps
module tb_frame_reader;
    localparam int BIT_DIV = 4;
    localparam int RD_LAT  = 2;
`ifdef SERIAL_PARITY_EN
    localparam int NB = 13;
`else
    localparam int NB = 12;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [11:0] rdDAT;
    logic [9:0]  rdADR;
    logic        bufSwitch, serDAT, serSTB, wordSTB, frameSTB;

    frame_reader #(.BIT_DIV(BIT_DIV), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .reset(reset), .enable(enable), .rdDAT(rdDAT), .rdADR(rdADR),
        .bufSwitch(bufSwitch), .serDAT(serDAT), .serSTB(serSTB), .wordSTB(wordSTB), .frameSTB(frameSTB)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM with RD_LAT=2: address registered once, data usable two edges after rdADR changes.
    logic [11:0] ram [0:1][0:1023];
    logic [9:0]  addr_q = '0;
    logic        bank_q = 1'b0;
    always @(posedge clk) begin
        addr_q <= rdADR;
        bank_q <= ~bufSwitch;
    end
    assign rdDAT = ram[bank_q][addr_q];

    typedef struct packed {
        logic [12:0] bits;
        logic        bs;
        logic        fs;
    } rec_t;

    rec_t        rxq[$];
    logic [12:0] cur = '0;
    int          nbits = 0;
    logic        cur_bs = 1'b0, cur_fs = 1'b0, bs_prev = 1'b0;
    int          wstb_cnt = 0, toggles = 0, since_frame = 0, last_frame_len = 0;

    always @(negedge clk) begin
        if (!reset) begin
            nbits   = 0;
            cur     = '0;
            bs_prev = bufSwitch;
        end else begin
            if (bufSwitch !== bs_prev) toggles++;
            bs_prev = bufSwitch;
            if (wordSTB) begin
                wstb_cnt++;
                if (frameSTB) begin
                    last_frame_len = since_frame;
                    since_frame = 0;
                end
                since_frame++;
            end
            if (serSTB) begin
                if (wordSTB) begin
                    cur = '0; nbits = 0; cur_bs = bufSwitch; cur_fs = frameSTB;
                end
                cur = {cur[11:0], serDAT};
                nbits++;
                if (nbits == NB) begin
                    rec_t r;
                    r.bits = cur; r.bs = cur_bs; r.fs = cur_fs;
                    rxq.push_back(r);
                    nbits = 0;
                end
            end
        end
    end

    // Frame model: next expected word address, frame count and bank select.
    logic [9:0] m_addr = '0;
    logic [3:0] m_fc = '0;
    logic       m_bs = 1'b0;

    function automatic logic [12:0] exp_bits(input logic [9:0] a, input logic [3:0] fc, input logic bank);
        logic [11:0] w;
        if (a % 4 == 0) w = {a[9:2], fc};
        else            w = ram[bank][a];
`ifdef SERIAL_PARITY_EN
        return {w, ($countones(w) % 2 == 0)};
`else
        return {1'b0, w};
`endif
    endfunction

    task automatic model_step(output logic [12:0] e, output logic ebs, output logic efs);
        e   = exp_bits(m_addr, m_fc, ~m_bs);
        ebs = (m_addr == 10'd1023) ? ~m_bs : m_bs;
        efs = (m_addr == 10'd0);
        if (m_addr == 10'd1023) begin
            m_bs = ~m_bs;
            m_fc = m_fc + 4'd1;
        end
        m_addr = m_addr + 10'd1;
    endtask

    task automatic wait_word(output rec_t r, output bit ok);
        int t = 0;
        while (rxq.size() == 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        ok = (rxq.size() != 0);
        if (ok) r = rxq.pop_front();
        else    r = '0;
    endtask

    task automatic test_reset();
        int e0, n;
        reset = 1'b0; enable = 1'b1;
        repeat (5) begin
            @(negedge clk);
            vectors++;
            if ({rdADR, bufSwitch, serDAT, serSTB, wordSTB, frameSTB} !== 15'h0) begin
                errors++;
                $display("FAIL reset_hold: outputs=%h required 0", {rdADR, bufSwitch, serDAT, serSTB, wordSTB, frameSTB});
            end
        end
        m_addr = '0; m_fc = '0; m_bs = 1'b0;
        reset = 1'b1;
        e0 = cyc + 1;
        n = 0;
        while (!frameSTB && n < 100) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (frameSTB !== 1'b1 || cyc != e0 + RD_LAT + 3) begin
            errors++;
            $display("FAIL first_frame_stb: at clock %0d (seen=%b) required clock %0d", cyc - e0, frameSTB, RD_LAT + 3);
        end
        vectors++;
        if ({serSTB, wordSTB} !== 2'b11) begin
            errors++;
            $display("FAIL first_strobes: ser/word=%b required 11", {serSTB, wordSTB});
        end
    endtask

    task automatic test_bit_pattern();
        int t0, tprev, n;
        logic [12:0] e;
        e = exp_bits(10'd1, 4'd0, 1'b1);
        tprev = 0;
        @(negedge clk);
        n = 0;
        while (!wordSTB && n < 200) begin
            @(negedge clk);
            n++;
        end
        t0 = cyc;
        for (int b = 0; b < NB; b++) begin
            if (b > 0) begin
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!serSTB && n < 20);
            end
            vectors++;
            if (serSTB !== 1'b1 || serDAT !== e[NB-1-b]) begin
                errors++;
                $display("FAIL word1_bit%0d: serDAT=%b serSTB=%b required %b", b, serDAT, serSTB, e[NB-1-b]);
            end
            if (b > 0) begin
                vectors++;
                if (cyc - tprev != BIT_DIV) begin
                    errors++;
                    $display("FAIL bit_spacing%0d: %0d clocks required %0d", b, cyc - tprev, BIT_DIV);
                end
            end
            tprev = cyc;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!wordSTB && n < 200);
        vectors++;
        if (wordSTB !== 1'b1 || cyc - t0 != NB * BIT_DIV) begin
            errors++;
            $display("FAIL word_length: %0d clocks required %0d", cyc - t0, NB * BIT_DIV);
        end
    endtask

    task automatic test_full_frame();
        logic [12:0] f1w0, f1w4;
        f1w0 = '0; f1w4 = '0;
        for (int i = 0; i < 1029; i++) begin
            rec_t r; bit ok; logic [12:0] e; logic ebs, efs;
            wait_word(r, ok);
            vectors++;
            if (!ok) begin
                errors++;
                $display("FAIL frame_word_timeout: word %0d not received, required within 400 clocks", i);
                break;
            end
            model_step(e, ebs, efs);
            vectors++;
            if (r.bits !== e) begin
                errors++;
                $display("FAIL frame_word%0d: data=%h required %h", i, r.bits, e);
            end
            vectors++;
            if (r.bs !== ebs || r.fs !== efs) begin
                errors++;
                $display("FAIL frame_flags%0d: bufSwitch/frameSTB=%b%b required %b%b", i, r.bs, r.fs, ebs, efs);
            end
`ifdef SERIAL_PARITY_EN
            if (i == 1 || i == 2) begin
                vectors++;
                if (r.bits[0] !== (i == 2)) begin
                    errors++;
                    $display("FAIL parity_word%0d: parity=%b required %b", i, r.bits[0], (i == 2));
                end
            end
`endif
            if (i == 1024) f1w0 = r.bits;
            if (i == 1028) f1w4 = r.bits;
        end
        vectors++;
        if (last_frame_len != 1024) begin
            errors++;
            $display("FAIL frame_len: %0d wordSTB required 1024", last_frame_len);
        end
        vectors++;
        if (toggles != 1) begin
            errors++;
            $display("FAIL bufswitch_toggles: %0d required 1", toggles);
        end
        vectors++;
        if (f1w0[NB-1:NB-12] !== 12'h001) begin
            errors++;
            $display("FAIL frame1_word0: %h required 001", f1w0[NB-1:NB-12]);
        end
        vectors++;
        if (f1w4[NB-1:NB-12] !== 12'h011) begin
            errors++;
            $display("FAIL frame1_word4: %h required 011", f1w4[NB-1:NB-12]);
        end
    endtask

    task automatic test_enable_drop();
        int n, base;
        rec_t r; bit ok; logic [12:0] e; logic ebs, efs;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!wordSTB && n < 200);
        repeat (10) @(negedge clk);
        enable = 1'b0;
        wait_word(r, ok);
        model_step(e, ebs, efs);
        vectors++;
        if (!ok || r.bits !== e) begin
            errors++;
            $display("FAIL drop_word5: data=%h ok=%b required %h", r.bits, ok, e);
        end
        base = wstb_cnt;
        repeat (150) @(negedge clk);
        vectors++;
        if (wstb_cnt != base || rxq.size() != 0) begin
            errors++;
            $display("FAIL drop_idle: %0d extra wordSTB required 0", wstb_cnt - base);
        end
        vectors++;
        if (bufSwitch !== m_bs) begin
            errors++;
            $display("FAIL drop_bufswitch: %b required %b", bufSwitch, m_bs);
        end
        enable = 1'b1;
        m_addr = '0;
        for (int i = 0; i < 2; i++) begin
            wait_word(r, ok);
            model_step(e, ebs, efs);
            vectors++;
            if (!ok || r.bits !== e || r.bs !== ebs || r.fs !== efs) begin
                errors++;
                $display("FAIL restart_word%0d: data=%h bs=%b fs=%b required %h %b %b", i, r.bits, r.bs, r.fs, e, ebs, efs);
            end
        end
    endtask

    task automatic test_reset_mid_word();
        int n;
        rec_t r; bit ok; logic [12:0] e; logic ebs, efs;
        for (int i = 2; i < 7; i++) begin
            wait_word(r, ok);
            model_step(e, ebs, efs);
            vectors++;
            if (!ok || r.bits !== e) begin
                errors++;
                $display("FAIL pre_reset_word%0d: data=%h required %h", i, r.bits, e);
            end
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!wordSTB && n < 200);
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        vectors++;
        if ({rdADR, bufSwitch, serDAT, serSTB, wordSTB, frameSTB} !== 15'h0) begin
            errors++;
            $display("FAIL midword_reset: outputs=%h required 0", {rdADR, bufSwitch, serDAT, serSTB, wordSTB, frameSTB});
        end
        repeat (3) @(negedge clk);
        rxq.delete();
        m_addr = '0; m_fc = '0; m_bs = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wait_word(r, ok);
            model_step(e, ebs, efs);
            vectors++;
            if (!ok || r.bits !== e || r.fs !== efs || r.bs !== ebs) begin
                errors++;
                $display("FAIL post_reset_word%0d: data=%h fs=%b bs=%b required %h %b %b", i, r.bits, r.fs, r.bs, e, efs, ebs);
            end
        end
    endtask

    initial begin
        for (int b = 0; b < 2; b++) begin
            for (int a = 0; a < 1024; a++) ram[b][a] = 12'($urandom);
`ifdef SERIAL_PARITY_EN
            ram[b][1] = 12'h001;
            ram[b][2] = 12'h003;
`else
            ram[b][1] = 12'hA5C;
`endif
        end
        test_reset();
        test_bit_pattern();
        test_full_frame();
        test_enable_drop();
        test_reset_mid_word();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
